// File: rtl/conv_pkg.sv
// Shared definitions for the pixel converters: PISO state encoding and default geometry.
package conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int PISO_N_DEF  = 3;
  localparam int PISO_PB_DEF = 8;

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out pixel converter: one N-pixel word in, N pixels out, pixel 0 first.
// Define PISO_DBUF_EN to add a one-word holding register for bubble-free streaming.
module piso
  import conv_pkg::*;
#(
  parameter int N  = PISO_N_DEF,
  parameter int PB = PISO_PB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2*PB*N-1:0] par_in,
  input  logic              par_valid,
  output logic              par_ready,
  output logic [2*PB-1:0]   ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_last
);

  localparam int PW = 2 * PB;
  localparam int WW = PW * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  piso_state_t   state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] sreg;
  logic          last_pix, par_xfer, ser_xfer;

  assign last_pix  = (cnt == LAST);
  assign ser_valid = (state == SHIFT);
  assign ser_out   = sreg[PW-1:0];
  assign ser_last  = ser_valid & last_pix;
  assign par_xfer  = par_valid & par_ready;
  assign ser_xfer  = ser_valid & ser_ready;

`ifdef PISO_DBUF_EN
  logic [WW-1:0] hold;
  logic          hold_full;

  assign par_ready = en & ~rst & ~hold_full;
`else
  assign par_ready = en & ~rst & (state == IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
`ifdef PISO_DBUF_EN
      hold      <= '0;
      hold_full <= 1'b0;
`endif
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
`ifdef PISO_DBUF_EN
      hold      <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (par_xfer) begin
            sreg  <= par_in;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_xfer) begin
            if (!last_pix) begin
              sreg <= sreg >> PW;
              cnt  <= cnt + 1'b1;
            end else begin
`ifdef PISO_DBUF_EN
              // Held word wins; a fresh word can only arrive here when the holder is empty.
              if (hold_full) begin
                sreg      <= hold;
                cnt       <= '0;
                hold_full <= 1'b0;
              end else if (par_xfer) begin
                sreg <= par_in;
                cnt  <= '0;
              end else begin
                cnt   <= '0;
                state <= IDLE;
              end
`else
              cnt   <= '0;
              state <= IDLE;
`endif
            end
          end
`ifdef PISO_DBUF_EN
          if (par_xfer && !(ser_xfer && last_pix)) begin
            hold      <= par_in;
            hold_full <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso (N=3, PB=8) with a pixel scoreboard; honours PISO_DBUF_EN.
module tb_piso;

  localparam int N  = 3;
  localparam int PB = 8;

  typedef struct {
    logic [15:0] pix;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, en, par_valid, ser_ready, par_ready, ser_valid, ser_last;
  logic [47:0]   par_in;
  logic [15:0]   ser_out;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   vcnt, gaps, pend;
  bit   seen, stats_clr;

  piso #(.N(N), .PB(PB)) dut (
    .clk(clk), .rst(rst), .en(en),
    .par_in(par_in), .par_valid(par_valid), .par_ready(par_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_last(ser_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pixels pushed on each accepted word, popped on each accepted pixel.
  always @(negedge clk) begin
    if (!rst && en && ser_valid && ser_ready) begin
      if (sb.size() == 0) chk("sb_extra_pixel", ser_valid, 1'b0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pix", ser_out, e.pix);
        chk("sb_last", ser_last, e.last);
      end
    end
    if (!rst && en && par_valid && par_ready)
      for (int k = 0; k < N; k++) sb.push_back('{par_in[16*k +: 16], (k == N - 1)});
  end

  // Valid-run statistics: total valid pixels and bubbles between the first and last.
  always @(negedge clk) begin
    if (stats_clr) begin
      vcnt = 0; gaps = 0; pend = 0; seen = 0;
    end else if (!rst) begin
      if (ser_valid) begin
        if (seen) gaps += pend;
        pend = 0; seen = 1; vcnt++;
      end else if (seen) pend++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [47:0] w, input bit keep);
    bit ok = 0;
    par_in    = w;
    par_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (par_ready) begin ok = 1; break; end
    end
    tick();
    if (!keep) par_valid = 1'b0;
    if (!ok) chk("send_timeout", par_ready, 1'b1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !ser_valid) begin ok = 1; break; end
    end
    if (!ok) chk("drain_timeout", sb.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; par_valid = 1'b0; ser_ready = 1'b1;
    par_in = '0; stats_clr = 1'b1;
    @(negedge clk);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_ser_out",   ser_out,   16'h0);
    chk("rst_ser_last",  ser_last,  1'b0);
    chk("rst_par_ready", par_ready, 1'b0);
    tick(); tick();
    rst = 1'b0; stats_clr = 1'b0;
    @(negedge clk);
    chk("idle_par_ready", par_ready, 1'b1);
    tick();

    // Single word, free-running downstream
    send(48'h3333_2222_1111, 0);
    @(negedge clk); chk("lat_valid", ser_valid, 1'b1); chk("lat_pix0", ser_out, 16'h1111);
    chk("lat_last0", ser_last, 1'b0);
    @(negedge clk); chk("pix1", ser_out, 16'h2222);
    @(negedge clk); chk("pix2", ser_out, 16'h3333); chk("last2", ser_last, 1'b1);
    @(negedge clk); chk("back_idle", ser_valid, 1'b0); chk("idle_ready", par_ready, 1'b1);
    tick();

    // Downstream stall holds the first pixel
    send(48'h3333_2222_1111, 0);
    ser_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", ser_valid, 1'b1);
      chk("stall_pix", ser_out, 16'h1111);
    end
    tick();
    ser_ready = 1'b1;
    drain();

    // Back-to-back words with par_valid held
    stats_clr = 1'b1;
    @(negedge clk); #1 stats_clr = 1'b0;
    tick();
    send(48'hCCCC_BBBB_AAAA, 1);
    send(48'hFFFF_EEEE_DDDD, 0);
    drain();
    chk("b2b_pixels", vcnt, 6);
`ifdef PISO_DBUF_EN
    chk("b2b_bubbles", gaps, 0);
`else
    chk("b2b_bubbles", gaps, 1);
`endif

    // Reset mid-word discards the tail
    send(48'h3333_2222_1111, 0);
    @(negedge clk); chk("rstmid_pix0", ser_out, 16'h1111);
    @(negedge clk); chk("rstmid_pix1", ser_out, 16'h2222);
    tick();
    rst = 1'b1;
    #1 chk("rstmid_async_valid", ser_valid, 1'b0);
    chk("rstmid_par_ready", par_ready, 1'b0);
    sb.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rstmid_no_tail", ser_valid, 1'b0);
    end
    tick();
    send(48'h6666_5555_4444, 0);
    @(negedge clk); chk("rstmid_restart", ser_out, 16'h4444);
    drain();

    // Enable drop during SHIFT flushes everything
    ser_ready = 1'b0;
    send(48'h9999_8888_7777, 0);
`ifdef PISO_DBUF_EN
    send(48'hDEAD_BEEF_CAFE, 0);
    @(negedge clk); chk("hold_full_ready", par_ready, 1'b0);
    tick();
`endif
    en = 1'b0;
    #1 chk("flush_par_ready", par_ready, 1'b0);
    tick();
    en = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("flush_valid", ser_valid, 1'b0);
    chk("flush_ready", par_ready, 1'b1);
    tick();
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("flush_no_held", ser_valid, 1'b0);
    end
    tick();
    send(48'h0303_0202_0101, 0);
    @(negedge clk); chk("flush_recover", ser_out, 16'h0101);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso.md
PISO -- requirements
Module: piso

Interface
REQ-001 Parameter N, default 3: pixels per parallel word.
REQ-002 Parameter PB, default 8: bits per pixel component; one pixel is 2*PB bits.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  block enable; low means synchronous flush.
REQ-006 par_in  input  2*PB*N  parallel word; pixel k occupies bits [2*PB*(k+1)-1 : 2*PB*k].
REQ-007 par_valid  input  1  par_in valid.
REQ-008 par_ready  output  1  block accepts par_in this cycle.
REQ-009 ser_out  output  2*PB  current serial pixel.
REQ-010 ser_valid  output  1  ser_out valid.
REQ-011 ser_ready  input  1  downstream accepts ser_out.
REQ-012 ser_last  output  1  ser_out is pixel N-1 of its word.

Function
REQ-013 Handshakes: par transfer = par_valid & par_ready; ser transfer = ser_valid & ser_ready.
REQ-014 States IDLE, SHIFT; pixel counter cnt, width max(1,$clog2(N)), range 0..N-1.
REQ-015 IDLE: ser_valid=0; par_ready=en; par transfer loads shift register with par_in, cnt=0, next state SHIFT.
REQ-016 Latency: first pixel on ser_out with ser_valid=1 exactly 1 cycle after the par transfer.
REQ-017 SHIFT: ser_valid=1; ser_out = low 2*PB bits of shift register; ser_last = (cnt==N-1).
REQ-018 Pixel order: pixel 0 first, pixel N-1 last.
REQ-019 Ser transfer with cnt<N-1: shift register shifts right by 2*PB, cnt+1.
REQ-020 Without ser transfer: ser_out, ser_last, cnt, shift register hold unchanged.
REQ-021 Ser transfer with cnt==N-1: word done; next state per REQ-027/028.
REQ-022 par_valid ignored when par_ready=0; par_in sampled only on par transfer.
REQ-023 en=0: synchronous flush next edge: state IDLE, cnt=0, shift register 0, holding register empty, ser_valid=0; par_ready=0 while en=0.
REQ-024 N=1: every ser transfer is last; ser_last=1 whenever ser_valid=1.

Reset
REQ-025 rst=1 asynchronously forces: state IDLE, cnt=0, shift register 0, holding register 0/empty, ser_valid=0, ser_last=0, ser_out=0.
REQ-026 par_ready=0 while rst=1; mid-word reset discards the remaining pixels, none emitted after release.

Configuration
REQ-027 Macro PISO_DBUF_EN undefined: par_ready=0 in SHIFT; last ser transfer -> IDLE; sustained throughput N pixels per N+1 cycles.
REQ-028 PISO_DBUF_EN defined: one-word holding register; par_ready = en & ~hold_full in any state; IDLE par transfer loads shift register directly.
REQ-029 PISO_DBUF_EN, SHIFT, par transfer not coinciding with last ser transfer: word stored in holding register.
REQ-030 PISO_DBUF_EN, last ser transfer: if hold_full, holding word moves to shift register, cnt=0, stay SHIFT, hold emptied; else if par transfer same cycle, par_in loads shift register directly, stay SHIFT; else -> IDLE.
REQ-031 PISO_DBUF_EN: back-to-back words stream N pixels per N cycles, no bubble.

Structure
REQ-032 Shared package conv_pkg holds state enum piso_state_t and default constants for N and PB.
REQ-033 Single module; no sub-module; holding register inline under PISO_DBUF_EN.

Verification
REQ-034 N=3,PB=8, par_in=48'h3333_2222_1111, ser_ready=1 -> ser_out 1111,2222,3333 on cycles 1..3 after transfer, ser_last only on 3333, then IDLE.
REQ-035 Same word, ser_ready=0 for 4 cycles after first pixel -> ser_out holds 1111 with ser_valid=1, resumes 2222,3333 in order.
REQ-036 Two words 48'hCCCC_BBBB_AAAA, 48'hFFFF_EEEE_DDDD, par_valid held, ser_ready=1 -> no macro: one ser_valid=0 bubble between AAAA..CCCC and DDDD..FFFF; PISO_DBUF_EN: six consecutive valid pixels, ser_last on CCCC and FFFF.
REQ-037 rst pulsed after 2222 emitted -> ser_valid=0 immediately; after release 3333 never appears; next word starts at pixel 0.
REQ-038 en=0 one cycle during SHIFT (hold full under PISO_DBUF_EN) -> ser_valid=0 next cycle, held word discarded, par_ready=1 after en returns.
